calc_ctrl: RTL and testbench
============================

Name: calc_ctrl

Overview:
- Sequencing controller for the calculator's shared 4-bit add/sub datapath.
- Accepts one operation request at a time over a valid/ready handshake.
- ADD/SUB: drives the shared datapath for one cycle and captures its result. MUL: runs an internal W-cycle shift-add.
- Returns a 2W-bit result plus flags over a valid/ready response handshake.
- Sits between the front-panel/input FSM and the arithmetic units.

Parameters:
W, 4, operand width in bits; result width is 2*W.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 reserved.
req_a  input  W  operand A (unsigned).
req_b  input  W  operand B (unsigned).
dp_x  output  W  operand x to the shared add/sub datapath.
dp_y  output  W  operand y to the shared add/sub datapath.
dp_sel  output  1  datapath function: 0 add, 1 subtract.
dp_result  input  W  datapath result, combinational from dp_x/dp_y/dp_sel.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_result  output  2W  result, zero-extended for ADD/SUB.
rsp_flag  output  1  ADD carry-out or SUB borrow; 0 for MUL.
rsp_err  output  1  reserved opcode received.
busy  output  1  state != IDLE.

Behaviour:
- One clock domain; clk and rst_n as named above. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE; req_ready = 1; busy = 0.
  - rsp_valid, rsp_result, rsp_flag, rsp_err, dp_x, dp_y, dp_sel all 0.
  - Internal a_q, b_q, op_q, acc, cnt all 0.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: register req_a, req_b and req_op into a_q, b_q and op_q.
  - Next state: op 00/01 -> EXEC; op 10 -> MUL with acc = 0, cnt = 0; op 11 -> RESP with rsp_err = 1 and rsp_result = 0.
- EXEC (exactly one cycle):
  - dp_x = a_q, dp_y = b_q, dp_sel = op_q[0].
  - At the end of the cycle, rsp_result is loaded with {W'b0, dp_result}.
  - rsp_flag for ADD = (dp_result < a_q), i.e. carry-out. rsp_flag for SUB = (a_q < b_q), i.e. borrow.
  - Next state: RESP.
- dp_x, dp_y and dp_sel are 0 in every state except EXEC (quiet bus).
- MUL (exactly W cycles, cnt = 0..W-1):
  - Each cycle: if b_q[cnt], then acc = acc + (a_q << cnt), computed in 2W bits with no overflow possible.
  - At cnt = W-1: rsp_result = final acc, rsp_flag = 0, next state RESP.
- RESP:
  - rsp_valid = 1. rsp_result, rsp_flag and rsp_err are held stable while rsp_ready = 0.
  - On rsp_ready: clear rsp_valid and rsp_err, return to IDLE.
  - req_ready = 0 throughout, so no new request is accepted until the cycle after the handshake completes.
- Latency, with the request accepted at edge 0:
  - ADD/SUB: rsp_valid high after edge 2.
  - MUL: rsp_valid high after edge W+1 (5 for W=4).
  - Reserved opcode: rsp_valid high after edge 1.
- Throughput: back-to-back requests are spaced by at least (latency + 1) cycles.
- req_valid while req_ready = 0 is ignored. The requester must hold the request until req_ready is sampled high.
- rst_n asserted mid-operation (any state): immediately return to the reset values. The in-flight request is discarded and no response is issued.
- Wrap-around:
  - ADD 15+1 gives result 0x00, flag 1.
  - SUB 0-1 gives result 0x0F, flag 1.
  - MUL 0*x gives result 0 after the full W cycles (no early exit).

Decomposition:
- Shared header calc_defs.vh holds:
  - Opcode constants: OP_ADD, OP_SUB, OP_MUL, OP_RSV.
  - FSM state encodings: S_IDLE, S_EXEC, S_MUL, S_RESP.
- One sub-module is natural: calc_mul_seq.
  - Holds the shift-add accumulator and counter.
  - Interface: start/done, W-bit a and b, 2W-bit product.
  - Instantiated once inside calc_ctrl.
- The add/sub datapath stays outside calc_ctrl and is connected through the dp_* ports.

Test Plan:
- ADD a=9, b=8 with rsp_ready=1 -> dp_x=9, dp_y=8, dp_sel=0 during EXEC; rsp_result=0x01, rsp_flag=1, rsp_valid 2 cycles after accept.
- SUB a=3, b=5 -> dp_sel=1; rsp_result=0x0E, rsp_flag=1. SUB a=7, b=2 -> rsp_result=0x05, rsp_flag=0.
- MUL a=15, b=15 -> rsp_result=0xE1, rsp_flag=0, rsp_valid exactly 5 cycles after accept; dp_x=dp_y=0 throughout.
- req_op=11, a=4, b=4 -> rsp_err=1, rsp_result=0, rsp_valid 1 cycle after accept.
- Backpressure: ADD 2+3 with rsp_ready held 0 for 3 cycles, plus a second req_valid asserted meanwhile:
  - rsp_valid held, rsp_result=0x05 stable, req_ready=0.
  - Second request accepted only after the handshake completes.
- Reset mid-MUL: assert rst_n=0 at cnt=2 -> all outputs 0 immediately, req_ready=1 after release, no rsp_valid; a new ADD 1+1 then gives 0x02.

Source files
------------

// File: rtl/calc_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the calculator sequencing controller.
package calc_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10,
        S_RESP = 2'b11
    } state_t;

endpackage

// File: rtl/calc_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle for exactly W cycles.
module calc_mul_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           run,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] term;

    assign a_ext = {{W{1'b0}}, a};
    assign term  = b[cnt] ? (a_ext << cnt) : '0;
    // product is the accumulator value after this cycle's add, so the
    // controller can capture the final result on the same edge as done.
    assign product = acc + term;
    assign done    = run && (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (start) begin
            acc <= '0;
            cnt <= '0;
        end else if (run) begin
            acc <= product;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencing controller: drives the shared add/sub datapath or the
// internal multiplier and returns results over a valid/ready response channel.
module calc_ctrl
    import calc_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [W-1:0]   req_a,
    input  logic [W-1:0]   req_b,
    output logic [W-1:0]   dp_x,
    output logic [W-1:0]   dp_y,
    output logic           dp_sel,
    input  logic [W-1:0]   dp_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_result,
    output logic           rsp_flag,
    output logic           rsp_err,
    output logic           busy
);

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    op_t            op_q;
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    // Carry-out for ADD shows up as a wrapped sum smaller than a; borrow for SUB is a < b.
    function automatic logic calc_flag(input op_t op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [W-1:0] r);
        return (op == OP_SUB) ? (a < b) : (r < a);
    endfunction

    assign mul_start = (state == S_IDLE) && req_valid && (req_op == OP_MUL);
    assign busy      = (state != S_IDLE);

    calc_mul_seq #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .run     (state == S_MUL),
        .a       (a_q),
        .b       (b_q),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            dp_x       <= '0;
            dp_y       <= '0;
            dp_sel     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flag   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q       <= req_a;
                        b_q       <= req_b;
                        op_q      <= op_t'(req_op);
                        req_ready <= 1'b0;
                        case (op_t'(req_op))
                            OP_ADD, OP_SUB: begin
                                // Datapath operands are registered here so they are valid for the whole EXEC cycle.
                                dp_x   <= req_a;
                                dp_y   <= req_b;
                                dp_sel <= req_op[0];
                                state  <= S_EXEC;
                            end
                            OP_MUL: state <= S_MUL;
                            default: begin
                                rsp_err    <= 1'b1;
                                rsp_result <= '0;
                                rsp_flag   <= 1'b0;
                                state      <= S_RESP;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    rsp_result <= {{W{1'b0}}, dp_result};
                    rsp_flag   <= calc_flag(op_q, a_q, b_q, dp_result);
                    dp_x       <= '0;
                    dp_y       <= '0;
                    dp_sel     <= 1'b0;
                    state      <= S_RESP;
                end
                S_MUL: begin
                    if (mul_done) begin
                        rsp_result <= mul_product;
                        rsp_flag   <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    // rsp_valid rises one cycle after entering RESP; the handshake only counts once it is up.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a behavioural model of the external add/sub datapath.
module tb_calc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [3:0] dp_x;
    logic [3:0] dp_y;
    logic       dp_sel;
    logic [3:0] dp_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_flag;
    logic       rsp_err;
    logic       busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign dp_result = dp_sel ? (dp_x - dp_y) : (dp_x + dp_y);

    calc_ctrl #(.W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .dp_x       (dp_x),
        .dp_y       (dp_y),
        .dp_sel     (dp_sel),
        .dp_result  (dp_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Present a request and return 1 cycle-phase after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        output bit ok);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Counts edges after acceptance until rsp_valid is seen; -1 when the bound expires.
    task automatic wait_rsp(output int lat, output bit dp_active);
        lat = -1; dp_active = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (dp_x != 0 || dp_y != 0 || dp_sel) dp_active = 1'b1;
            if (rsp_valid) begin lat = n; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 4'd0; req_b = 4'd0; rsp_ready = 1'b1;
        #12;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        checks++; if ({rsp_valid, rsp_result, rsp_flag, rsp_err} !== 11'd0)
            $display("FAIL reset_rsp got %b/%h/%b/%b exp 0", rsp_valid, rsp_result, rsp_flag, rsp_err); else passed++;
        checks++; if ({dp_x, dp_y, dp_sel} !== 9'd0)
            $display("FAIL reset_dp got %h/%h/%b exp 0", dp_x, dp_y, dp_sel); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        bit ok; int lat; bit dpa;
        send(2'b00, 4'd9, 4'd8, ok);
        checks++; if ({dp_x, dp_y, dp_sel} !== {4'd9, 4'd8, 1'b0})
            $display("FAIL add_dp got %h/%h/%b exp 9/8/0", dp_x, dp_y, dp_sel); else passed++;
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0)
            $display("FAIL add_busy got busy=%b ready=%b exp 1/0", busy, req_ready); else passed++;
        wait_rsp(lat, dpa);
        checks++; if (lat !== 2) $display("FAIL add_latency got %0d exp 2", lat); else passed++;
        checks++; if ({rsp_result, rsp_flag, rsp_err} !== {8'h01, 1'b1, 1'b0})
            $display("FAIL add_result got %h/%b/%b exp 01/1/0", rsp_result, rsp_flag, rsp_err); else passed++;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL add_handshake got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); else passed++;
    endtask

    task automatic test_sub();
        bit ok; int lat; bit dpa;
        send(2'b01, 4'd3, 4'd5, ok);
        checks++; if (dp_sel !== 1'b1) $display("FAIL sub_dp_sel got %b exp 1", dp_sel); else passed++;
        wait_rsp(lat, dpa);
        checks++; if (lat !== 2 || rsp_result !== 8'h0E || rsp_flag !== 1'b1)
            $display("FAIL sub_3_5 got lat=%0d %h/%b exp 2 0e/1", lat, rsp_result, rsp_flag); else passed++;
        @(posedge clk); #1;
        send(2'b01, 4'd7, 4'd2, ok);
        wait_rsp(lat, dpa);
        checks++; if (lat !== 2 || rsp_result !== 8'h05 || rsp_flag !== 1'b0)
            $display("FAIL sub_7_2 got lat=%0d %h/%b exp 2 05/0", lat, rsp_result, rsp_flag); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        bit ok; int lat; bit dpa;
        send(2'b00, 4'd15, 4'd1, ok);
        wait_rsp(lat, dpa);
        checks++; if (rsp_result !== 8'h00 || rsp_flag !== 1'b1)
            $display("FAIL add_15_1 got %h/%b exp 00/1", rsp_result, rsp_flag); else passed++;
        @(posedge clk); #1;
        send(2'b01, 4'd0, 4'd1, ok);
        wait_rsp(lat, dpa);
        checks++; if (rsp_result !== 8'h0F || rsp_flag !== 1'b1)
            $display("FAIL sub_0_1 got %h/%b exp 0f/1", rsp_result, rsp_flag); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        bit ok; int lat; bit dpa;
        send(2'b10, 4'd15, 4'd15, ok);
        wait_rsp(lat, dpa);
        checks++; if (lat !== 5) $display("FAIL mul_latency got %0d exp 5", lat); else passed++;
        checks++; if (rsp_result !== 8'hE1 || rsp_flag !== 1'b0)
            $display("FAIL mul_15_15 got %h/%b exp e1/0", rsp_result, rsp_flag); else passed++;
        checks++; if (dpa !== 1'b0 || dp_x !== 4'd0) $display("FAIL mul_dp_quiet got %b exp 0", dpa); else passed++;
        @(posedge clk); #1;
        send(2'b10, 4'd0, 4'd7, ok);
        wait_rsp(lat, dpa);
        checks++; if (lat !== 5 || rsp_result !== 8'h00)
            $display("FAIL mul_0_7 got lat=%0d %h exp 5 00", lat, rsp_result); else passed++;
        @(posedge clk); #1;
        send(2'b10, 4'd13, 4'd11, ok);
        wait_rsp(lat, dpa);
        checks++; if (rsp_result !== 8'h8F) $display("FAIL mul_13_11 got %h exp 8f", rsp_result); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reserved();
        bit ok; int lat; bit dpa;
        send(2'b11, 4'd4, 4'd4, ok);
        wait_rsp(lat, dpa);
        checks++; if (lat !== 1) $display("FAIL rsv_latency got %0d exp 1", lat); else passed++;
        checks++; if (rsp_err !== 1'b1 || rsp_result !== 8'h00 || rsp_flag !== 1'b0)
            $display("FAIL rsv_result got err=%b %h/%b exp 1 00/0", rsp_err, rsp_result, rsp_flag); else passed++;
        @(posedge clk); #1;
        checks++; if (rsp_err !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL rsv_clear got err=%b valid=%b exp 0/0", rsp_err, rsp_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; bit dpa; int bad;
        rsp_ready = 1'b0;
        send(2'b00, 4'd2, 4'd3, ok);
        wait_rsp(lat, dpa);
        checks++; if (lat !== 2 || rsp_result !== 8'h05)
            $display("FAIL bp_first got lat=%0d %h exp 2 05", lat, rsp_result); else passed++;
        req_op = 2'b00; req_a = 4'd4; req_b = 4'd4; req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== 8'h05 || req_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad); else passed++;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL bp_release got valid=%b ready=%b busy=%b exp 0/1/0", rsp_valid, req_ready, busy); else passed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || dp_x !== 4'd4)
            $display("FAIL bp_second_accept got busy=%b dp_x=%h exp 1/4", busy, dp_x); else passed++;
        wait_rsp(lat, dpa);
        checks++; if (lat !== 2 || rsp_result !== 8'h08 || rsp_flag !== 1'b0)
            $display("FAIL bp_second got lat=%0d %h/%b exp 2 08/0", lat, rsp_result, rsp_flag); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        bit ok; int lat; bit dpa; int seen;
        send(2'b10, 4'd15, 4'd15, ok);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, rsp_result, rsp_flag, rsp_err, busy, dp_x, dp_y, dp_sel} !== 21'd0 || req_ready !== 1'b1)
            $display("FAIL midrst_outputs got valid=%b res=%h busy=%b ready=%b exp 0/00/0/1",
                     rsp_valid, rsp_result, busy, req_ready); else passed++;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++; if (seen !== 0 || req_ready !== 1'b1)
            $display("FAIL midrst_no_rsp got %0d valid cycles ready=%b exp 0/1", seen, req_ready); else passed++;
        @(posedge clk); #1;
        send(2'b00, 4'd1, 4'd1, ok);
        wait_rsp(lat, dpa);
        checks++; if (lat !== 2 || rsp_result !== 8'h02 || rsp_flag !== 1'b0)
            $display("FAIL midrst_add got lat=%0d %h/%b exp 2 02/0", lat, rsp_result, rsp_flag); else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_wrap();
        test_mul();
        test_reserved();
        test_back_to_back();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
